// File: rtl/ssd_ascii_scan_driver.sv
// Four-digit common-anode seven-segment scan driver for ASCII words.
// A rising edge on ready_in captures a word; an optional blink blanks the anodes.
module ssd_ascii_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] digits_in,
  input  logic        ready_in,
  input  logic        blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        load_ack
);

  localparam int unsigned REFRESH_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned FRAME_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [REFRESH_W-1:0] REFRESH_MAX = REFRESH_W'(REFRESH_DIV - 1);
  localparam logic [FRAME_W-1:0]   FRAME_MAX   = FRAME_W'(BLINK_DIV - 1);

  logic [31:0]          r_disp;
  logic                 r_ready_q;
  logic [REFRESH_W-1:0] r_refresh_cnt;
  logic [1:0]           r_scan_idx;
  logic [FRAME_W-1:0]   r_frame_cnt;
  logic                 r_blink_on;
  logic [6:0]           r_seg;
  logic                 r_dp;
  logic [3:0]           r_an;
  logic                 r_load_ack;

  logic                 w_load;
  logic                 w_slot_end;
  logic                 w_frame_end;
  logic [7:0]           w_byte;
  logic [6:0]           w_seg;
  logic                 w_dp;
  logic [3:0]           w_an_scan;

  assign w_load      = ready_in & ~r_ready_q;
  assign w_slot_end  = (r_refresh_cnt == REFRESH_MAX);
  assign w_frame_end = w_slot_end & (r_scan_idx == 2'd3);

  // Byte and anode selection for the slot currently being scanned
  always_comb begin
    w_byte    = 8'h00;
    w_an_scan = 4'hF;
    case (r_scan_idx)
      2'd0: begin w_byte = r_disp[7:0];   w_an_scan = 4'b1110; end
      2'd1: begin w_byte = r_disp[15:8];  w_an_scan = 4'b1101; end
      2'd2: begin w_byte = r_disp[23:16]; w_an_scan = 4'b1011; end
      2'd3: begin w_byte = r_disp[31:24]; w_an_scan = 4'b0111; end
      default: begin w_byte = 8'h00;      w_an_scan = 4'hF;    end
    endcase
  end

  // ASCII to active-low {g,f,e,d,c,b,a}; unknown bytes light only the decimal point
  always_comb begin
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    case (w_byte)
      8'h30: w_seg = 7'h40;
      8'h31: w_seg = 7'h79;
      8'h32: w_seg = 7'h24;
      8'h33: w_seg = 7'h30;
      8'h34: w_seg = 7'h19;
      8'h35: w_seg = 7'h12;
      8'h36: w_seg = 7'h02;
      8'h37: w_seg = 7'h78;
      8'h38: w_seg = 7'h00;
      8'h39: w_seg = 7'h10;
      8'h72: w_seg = 7'h2F;
      8'h64: w_seg = 7'h21;
      8'h6C: w_seg = 7'h47;
      8'h75: w_seg = 7'h63;
      8'h63: w_seg = 7'h27;
      8'h2D: w_seg = 7'h3F;
      8'h00,
      8'h20: w_seg = 7'h7F;
      default: begin
        w_seg = 7'h7F;
        w_dp  = 1'b0;
      end
    endcase
  end

  // Word capture on the rising edge of ready_in
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready_q  <= 1'b0;
      r_disp     <= '0;
      r_load_ack <= 1'b0;
    end else begin
      r_ready_q  <= ready_in;
      r_load_ack <= w_load;
      if (w_load) begin
        r_disp <= digits_in;
      end
    end
  end

  // Slot timer and digit index; a load never disturbs the scan phase
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
    end else begin
      if (w_slot_end) begin
        r_refresh_cnt <= '0;
        r_scan_idx    <= r_scan_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + REFRESH_W'(1);
      end
    end
  end

  // Blink phase: counts full frames, restarts in the on phase after every load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_load) begin
      r_frame_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_frame_cnt == FRAME_MAX) begin
        r_frame_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Registered display drive, one clock behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= 4'hF;
    end else begin
      r_seg <= w_seg;
      r_dp  <= w_dp;
      r_an  <= (blink_en & ~r_blink_on) ? 4'hF : w_an_scan;
    end
  end

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign load_ack = r_load_ack;

endmodule

// File: tb/tb_ssd_ascii_scan_driver.sv
// Directed bench for ssd_ascii_scan_driver with REFRESH_DIV=4, BLINK_DIV=2.
// Expected display slot after edge k (counted from reset release) is ((k-1)/4)%4.
module tb_ssd_ascii_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] digits_in;
  logic        ready_in;
  logic        blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        load_ack;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int s;
  logic off;

  logic [6:0] seg_rdlu [4];
  logic [6:0] seg_0123 [4];
  logic [6:0] seg_ac   [4];
  logic       dp_ac    [4];
  logic [3:0] an_tbl   [4];

  always #5 clk = ~clk;

  ssd_ascii_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .ready_in  (ready_in),
    .blink_en  (blink_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .load_ack  (load_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int slot_of(input int c);
    return ((c - 1) / 4) % 4;
  endfunction

  initial begin
    an_tbl[0] = 4'hE; an_tbl[1] = 4'hD; an_tbl[2] = 4'hB; an_tbl[3] = 4'h7;
    seg_rdlu[0] = 7'h63; seg_rdlu[1] = 7'h47; seg_rdlu[2] = 7'h21; seg_rdlu[3] = 7'h2F;
    seg_0123[0] = 7'h30; seg_0123[1] = 7'h24; seg_0123[2] = 7'h79; seg_0123[3] = 7'h40;
    seg_ac[0] = 7'h7F; seg_ac[1] = 7'h7F; seg_ac[2] = 7'h27; seg_ac[3] = 7'h7F;
    dp_ac[0] = 1'b0;   dp_ac[1] = 1'b1;   dp_ac[2] = 1'b1;   dp_ac[3] = 1'b1;

    // Reset values
    rst = 1'b1; ready_in = 1'b0; blink_en = 1'b0; digits_in = 32'h0;
    tick(); tick();
    chk("rst_an",  32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp",  32'(dp), 32'h1);
    chk("rst_ack", 32'(load_ack), 32'h0);
    rst = 1'b0; cyc = 0;

    // Idle after reset: blank display, no load
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("idle_seg", 32'(seg), 32'h7F);
      chk("idle_dp",  32'(dp), 32'h1);
      chk("idle_ack", 32'(load_ack), 32'h0);
    end

    // Load "rdlu" with a one-cycle ready pulse (capture at edge 9)
    digits_in = 32'h72646C75; ready_in = 1'b1;
    tick();
    chk("rdlu_ack", 32'(load_ack), 32'h1);
    ready_in = 1'b0;
    for (int k = 10; k <= 40; k++) begin
      tick();
      s = slot_of(cyc);
      chk("rdlu_an",  32'(an), 32'(an_tbl[s]));
      chk("rdlu_seg", 32'(seg), 32'(seg_rdlu[s]));
      chk("rdlu_dp",  32'(dp), 32'h1);
      chk("rdlu_ack_low", 32'(load_ack), 32'h0);
    end

    // ready_in held high for 50 cycles while digits_in changes: one load only
    digits_in = 32'h30313233; ready_in = 1'b1; ack_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (load_ack) ack_cnt++;
      chk("hold_ack", 32'(load_ack), 32'(i == 0));
      digits_in = 32'h34353637 + 32'(i);
    end
    chk("hold_ack_count", 32'(ack_cnt), 32'd1);
    ready_in = 1'b0; digits_in = 32'hFFFFFFFF;
    for (int k = 91; k <= 106; k++) begin
      tick();
      s = slot_of(cyc);
      chk("hold_an",  32'(an), 32'(an_tbl[s]));
      chk("hold_seg", 32'(seg), 32'(seg_0123[s]));
      chk("hold_dp",  32'(dp), 32'h1);
    end

    // Error marker, blank bytes and 'c' (capture at edge 107)
    digits_in = 32'h00630041; ready_in = 1'b1;
    tick();
    chk("ac_ack", 32'(load_ack), 32'h1);
    ready_in = 1'b0;
    for (int k = 108; k <= 123; k++) begin
      tick();
      s = slot_of(cyc);
      chk("ac_an",  32'(an), 32'(an_tbl[s]));
      chk("ac_seg", 32'(seg), 32'(seg_ac[s]));
      chk("ac_dp",  32'(dp), 32'(dp_ac[s]));
    end

    // Blink: load at edge 124, off outputs 145..176 and 209..240
    blink_en = 1'b1; digits_in = 32'h72646C75; ready_in = 1'b1;
    tick();
    ready_in = 1'b0;
    for (int k = 125; k <= 216; k++) begin
      tick();
      s = slot_of(cyc);
      off = ((cyc >= 145) && (cyc <= 176)) || (cyc >= 209);
      chk("blink_an",  32'(an), off ? 32'hF : 32'(an_tbl[s]));
      chk("blink_seg", 32'(seg), 32'(seg_rdlu[s]));
    end

    // Load mid-off-phase (edge 217): display returns on the following edge
    digits_in = 32'h30313233; ready_in = 1'b1;
    tick();
    chk("midoff_an_load_edge", 32'(an), 32'hF);
    chk("midoff_ack", 32'(load_ack), 32'h1);
    ready_in = 1'b0;
    tick();
    chk("midoff_an_restored", 32'(an), 32'hB);
    chk("midoff_seg", 32'(seg), 32'h79);
    for (int k = 219; k <= 244; k++) begin
      tick();
      s = slot_of(cyc);
      chk("reblink_an",  32'(an), (cyc >= 241) ? 32'hF : 32'(an_tbl[s]));
      chk("reblink_seg", 32'(seg), 32'(seg_0123[s]));
    end

    // blink_en deasserted during an off phase: anodes return next cycle
    blink_en = 1'b0;
    tick();
    chk("blink_dis_an",  32'(an), 32'hD);
    chk("blink_dis_seg", 32'(seg), 32'h24);

    // Reset mid-scan with ready_in high, then reload on release
    for (int k = 246; k <= 250; k++) tick();
    digits_in = 32'h2D2D2D2D; ready_in = 1'b1; rst = 1'b1;
    tick();
    chk("rst2_an",  32'(an), 32'hF);
    chk("rst2_seg", 32'(seg), 32'h7F);
    chk("rst2_dp",  32'(dp), 32'h1);
    chk("rst2_ack", 32'(load_ack), 32'h0);
    rst = 1'b0; cyc = 0;
    tick();
    chk("reload_ack", 32'(load_ack), 32'h1);
    chk("reload_an0", 32'(an), 32'hE);
    chk("reload_seg_old", 32'(seg), 32'h7F);
    tick();
    chk("reload_ack_low", 32'(load_ack), 32'h0);
    chk("reload_an1", 32'(an), 32'hE);
    chk("reload_seg_new", 32'(seg), 32'h3F);
    ready_in = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ssd_ascii_scan_driver.md
Name: ssd_ascii_scan_driver

Overview:
- Downstream consumer of the move-to-display stage's four-character ASCII word (`ssd_digits`) and its `ready` flag.
- Latches a new word on each rising edge of `ready`, decodes each byte to seven-segment patterns and time-multiplexes the 4-digit common-anode display.
- Optional blink lets the game flash the move sequence during the "memorise" phase.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot (100 MHz gives 1 kHz per digit); minimum 2.
- BLINK_DIV, 125, full scan frames (4 slots each) per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- digits_in  input  32  four ASCII bytes; byte k (bits 8k+7:8k) drives digit k; digit 3 is leftmost.
- ready_in  input  1  level from the upstream stage; a rising edge means digits_in is valid.
- blink_en  input  1  1 = blank the display during the off phase.
- seg  output  7  {g,f,e,d,c,b,a}, active-low, registered.
- dp  output  1  decimal point, active-low, registered.
- an  output  4  anode enables, active-low one-hot, registered.
- load_ack  output  1  one-cycle pulse the cycle after a word is captured.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge), all state cleared:
  - disp_reg=0 (all blank), ready_q=0, refresh_cnt=0, scan_idx=0, frame_cnt=0, blink_on=1.
  - Outputs: seg=7'h7F, dp=1, an=4'hF, load_ack=0.
  - rst overrides every other event in the same cycle.
- Load:
  - load = ready_in & ~ready_q; ready_q <= ready_in every cycle.
  - On load: disp_reg <= digits_in, blink_on <= 1, frame_cnt <= 0.
  - load_ack=1 on the next cycle only.
  - ready_in held high gives exactly one load.
  - ready_in already high when rst deasserts gives a load on the first cycle out of reset.
- Scan:
  - refresh_cnt counts 0..REFRESH_DIV-1 and wraps.
  - On wrap: scan_idx <= scan_idx+1 (mod 4, 3→0).
  - When scan_idx wraps 3→0, frame_cnt increments. When frame_cnt reaches BLINK_DIV-1 at that event, frame_cnt <= 0 and blink_on toggles.
  - Load does not reset refresh_cnt or scan_idx.
- Output register, updated every cycle with one clock of latency from scan_idx, disp_reg and blink_on:
  - an = ~(4'b0001 << scan_idx), forced to 4'hF when blink_en & ~blink_on.
  - seg/dp = decode(disp_reg byte[scan_idx]).
- Decode (seg value, dp=1 unless stated):
  - Digits: '0' 40, '1' 79, '2' 24, '3' 30, '4' 19, '5' 12, '6' 02, '7' 78, '8' 00, '9' 10.
  - Letters: 'r' 2F, 'd' 21, 'l' 47, 'u' 63, 'c' 27, '-' 3F.
  - Blank: 0x00 and ' ' give 7F.
  - Any other byte gives seg=7F, dp=0 (error marker).
- Simultaneous load and scan wrap: both take effect; the new data appears on the slot being entered.
- blink_en deassert: anodes return the next cycle; blink_on keeps running.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2):
- Reset, then hold: an=F, seg=7F, dp=1, load_ack=0 indefinitely with ready_in=0.
- digits_in="rdlu" (0x72646C75), pulse ready_in → load_ack pulses once. Each slot lasts 4 cycles:
  - an=E, seg=63 ('u')
  - an=D, seg=47 ('l')
  - an=B, seg=21 ('d')
  - an=7, seg=2F ('r')
  - then repeats.
- Hold ready_in high for 50 cycles while changing digits_in → only the first value is displayed; exactly one load_ack.
- digits_in=0x00630041 → digit0 ('A') seg=7F, dp=0; digit1 blank 7F; digit2 ('c') 27; digit3 blank 7F.
- blink_en=1 → an=F for 32 cycles, normal for 32 cycles, alternating. A new load mid-off-phase restores the display on the next cycle.
- Assert rst mid-scan with ready_in=1 → outputs return to reset values the next cycle. After release, the held-high ready_in reloads digits_in and load_ack pulses.
